// File: rtl/sseg_pkg.sv
// Constants, state encoding and digit helpers shared by the BCD converter
// and the downstream seven-segment decoder.
package sseg_pkg;

  localparam logic [3:0] DIGIT_ERR   = 4'hE;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam int         NUM_DIGITS  = 4;
  localparam int         BCD_W       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  // Leading zeros become blanks, scanning from the thousands digit down to
  // the tens digit; the ones digit always shows.
  function automatic logic [BCD_W-1:0] blank_lz(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    r = d;
    if (d[15:12] == 4'h0) begin
      r[15:12] = DIGIT_BLANK;
      if (d[11:8] == 4'h0) begin
        r[11:8] = DIGIT_BLANK;
        if (d[7:4] == 4'h0) r[7:4] = DIGIT_BLANK;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the calculator core (master) and the
// binary-to-BCD converter (slave).
interface bin2bcd_seq_if #(
  parameter int BIN_W = 14
) ();
  import sseg_pkg::*;

  // start is a single-cycle request, honoured only while busy is low;
  // done pulses for one cycle when the digit outputs take a new value.
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       leftmost;
  logic [3:0]       left_center;
  logic [3:0]       right_center;
  logic [3:0]       rightmost;
  state_t           dbg_state;

  modport master (
    output start, bin_in,
    input  busy, done, ovf, leftmost, left_center, right_center, rightmost,
           dbg_state
  );

  modport slave (
    input  start, bin_in,
    output busy, done, ovf, leftmost, left_center, right_center, rightmost,
           dbg_state
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  always_comb begin
    o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with registered digits.
// Optional leading-zero blanking is enabled by defining BIN2BCD_LZ_BLANK_EN.
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic         clk,
  input  logic         rst,
  bin2bcd_seq_if.slave bus
);

  localparam int               CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_V = BIN_W'(MAX_VAL);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_scratch;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_pend;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic [BCD_W-1:0] r_digits;

  logic [BCD_W-1:0] w_adj;
  logic [BCD_W-1:0] w_shifted;
  logic [BCD_W-1:0] w_result;
  logic             w_last;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib (r_scratch[4*g +: 4]),
      .o_nib (w_adj[4*g +: 4])
    );
  end

  assign w_shifted = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
  assign w_last    = (r_state == SHIFT) && (r_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == CNT_W'(1)) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output flags and digits are registered on the edge into their state, so
  // LOAD is the cycle in which done and the fresh digits are visible.
  always_comb begin
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == LOAD);
`ifdef BIN2BCD_LZ_BLANK_EN
    w_result   = r_ovf_pend ? {NUM_DIGITS{DIGIT_ERR}} : blank_lz(w_shifted);
`else
    w_result   = r_ovf_pend ? {NUM_DIGITS{DIGIT_ERR}} : w_shifted;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin      <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_digits   <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (r_state == IDLE && bus.start) begin
        r_bin      <= bus.bin_in;
        r_scratch  <= '0;
        r_cnt      <= CNT_W'(BIN_W);
        r_ovf_pend <= (bus.bin_in > MAX_V);
      end else if (r_state == SHIFT) begin
        r_scratch <= w_shifted;
        r_bin     <= r_bin << 1;
        r_cnt     <= r_cnt - CNT_W'(1);
      end
      if (w_last) begin
        r_digits <= w_result;
        r_ovf    <= r_ovf_pend;
      end
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.ovf          = r_ovf;
  assign bus.leftmost     = r_digits[15:12];
  assign bus.left_center  = r_digits[11:8];
  assign bus.right_center = r_digits[7:4];
  assign bus.rightmost    = r_digits[3:0];
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, digit values, overflow, ignored
// start, reset abort and back-to-back conversions.
module tb_bin2bcd_seq;
  import sseg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(14)) bus ();

  bin2bcd_seq #(.BIN_W(14), .MAX_VAL(9999)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] w_dig;
  assign w_dig = {bus.leftmost, bus.left_center, bus.right_center, bus.rightmost};

`ifdef BIN2BCD_LZ_BLANK_EN
  localparam logic [15:0] EXP_0  = 16'hFFF0;
  localparam logic [15:0] EXP_42 = 16'hFF42;
  localparam logic [15:0] EXP_5  = 16'hFFF5;
  localparam logic [15:0] EXP_7  = 16'hFFF7;
`else
  localparam logic [15:0] EXP_0  = 16'h0000;
  localparam logic [15:0] EXP_42 = 16'h0042;
  localparam logic [15:0] EXP_5  = 16'h0005;
  localparam logic [15:0] EXP_7  = 16'h0007;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with v and watch 20 cycles; tick 1 is the sampling edge.
  task automatic run_conv(input logic [13:0] v, output int lat,
                          output int busy_cyc, output int n_done);
    bus.bin_in = v;
    bus.start  = 1'b1;
    lat = 0; busy_cyc = 0; n_done = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) begin
        bus.start  = 1'b0;
        bus.bin_in = 14'($urandom_range(0, 16383));
      end
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        n_done++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.bin_in = 14'd1234;
    tick(); tick();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", bus.done); end
    n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b exp 0", bus.ovf); end
    n_tests++; if (w_dig !== 16'h0000) begin n_fail++; $display("FAIL reset_digits: got %h exp 0000", w_dig); end
    n_tests++; if (bus.dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp %0d", bus.dbg_state, IDLE); end
    rst = 1'b0; bus.start = 1'b0;
    tick();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b exp 0", bus.busy); end
  endtask

  task automatic test_basic();
    int lat, bc, nd;
    run_conv(14'd1234, lat, bc, nd);
    n_tests++; if (lat !== 15) begin n_fail++; $display("FAIL basic_latency: got %0d exp 15", lat); end
    n_tests++; if (bc !== 15) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d exp 15", bc); end
    n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d exp 1", nd); end
    n_tests++; if (w_dig !== 16'h1234) begin n_fail++; $display("FAIL basic_digits: got %h exp 1234", w_dig); end
    n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b exp 0", bus.ovf); end
  endtask

  task automatic test_values();
    logic [13:0] vals [7] = '{14'd0, 14'd42, 14'd9999, 14'd10000, 14'd5, 14'd16383, 14'd7};
    logic [15:0] digs [7] = '{EXP_0, EXP_42, 16'h9999, 16'hEEEE, EXP_5, 16'hEEEE, EXP_7};
    logic        ovfs [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int lat, bc, nd;
    logic [15:0] e;
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back(digs[k]);
      run_conv(vals[k], lat, bc, nd);
      e = exp_q.pop_front();
      n_tests++; if (lat !== 15) begin n_fail++; $display("FAIL value_latency[%0d]: got %0d exp 15", vals[k], lat); end
      n_tests++; if (w_dig !== e) begin n_fail++; $display("FAIL value_digits[%0d]: got %h exp %h", vals[k], w_dig, e); end
      n_tests++; if (bus.ovf !== ovfs[k]) begin n_fail++; $display("FAIL value_ovf[%0d]: got %b exp %b", vals[k], bus.ovf, ovfs[k]); end
    end
  endtask

  task automatic test_ignored_start();
    int nd = 0, first = 0;
    bus.bin_in = 14'd1234; bus.start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) bus.start = 1'b0;
      if (i == 5) begin bus.start = 1'b1; bus.bin_in = 14'd5678; end
      if (i == 6) bus.start = 1'b0;
      if (bus.done) begin nd++; if (first == 0) first = i; end
    end
    n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d exp 1", nd); end
    n_tests++; if (first !== 15) begin n_fail++; $display("FAIL ignore_latency: got %0d exp 15", first); end
    n_tests++; if (w_dig !== 16'h1234) begin n_fail++; $display("FAIL ignore_digits: got %h exp 1234", w_dig); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy: got %b exp 0", bus.busy); end
  endtask

  task automatic test_rst_abort();
    int lat, bc, nd;
    run_conv(14'd1234, lat, bc, nd);
    n_tests++; if (w_dig !== 16'h1234) begin n_fail++; $display("FAIL abort_pre_digits: got %h exp 1234", w_dig); end
    bus.bin_in = 14'd5678; bus.start = 1'b1;
    nd = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 1) bus.start = 1'b0;
      if (bus.done) nd++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b exp 0", bus.busy); end
    n_tests++; if (w_dig !== 16'h0000) begin n_fail++; $display("FAIL abort_digits: got %h exp 0000", w_dig); end
    for (int i = 0; i < 20; i++) begin
      if (bus.done) nd++;
      tick();
    end
    n_tests++; if (nd !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d exp 0", nd); end
    run_conv(14'd5678, lat, bc, nd);
    n_tests++; if (lat !== 15) begin n_fail++; $display("FAIL abort_restart_latency: got %0d exp 15", lat); end
    n_tests++; if (w_dig !== 16'h5678) begin n_fail++; $display("FAIL abort_restart_digits: got %h exp 5678", w_dig); end
  endtask

  task automatic test_back_to_back();
    int nd = 0, prev = 0, unsteady = 0;
    bus.bin_in = 14'd321; bus.start = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (bus.done) begin
        nd++;
        if (nd == 1) begin
          n_tests++; if (i !== 15) begin n_fail++; $display("FAIL b2b_first_latency: got %0d exp 15", i); end
        end else begin
          n_tests++; if (i - prev !== 16) begin n_fail++; $display("FAIL b2b_spacing: got %0d exp 16", i - prev); end
        end
        prev = i;
      end
      if (nd > 0 && w_dig !== 16'h0321) unsteady++;
    end
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_tests++; if (nd !== 4) begin n_fail++; $display("FAIL b2b_done_count: got %0d exp 4", nd); end
    n_tests++; if (unsteady !== 0) begin n_fail++; $display("FAIL b2b_steady_digits: got %0d bad cycles exp 0", unsteady); end
    n_tests++; if (w_dig !== 16'h0321) begin n_fail++; $display("FAIL b2b_final_digits: got %h exp 0321", w_dig); end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.bin_in = '0;
    rst        = 1'b1;
    test_reset();
    test_basic();
    test_values();
    test_ignored_start();
    test_rst_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
